// File: rtl/embertrail_data_mem.sv
// embertrail_data_mem: dual-port 16-bit word data memory for the Embertrail core.
// Two independent accesses per cycle (slot 1 = low half, slot 2 = high half of the
// packed buses). Read data is registered with one cycle of latency. After reset the
// array is cleared one word per cycle, and traffic is only accepted once that is done.
// Ports:
//   iClock, iReset        clock; synchronous active-high reset
//   iDataAddrBus          {port2 addr, port1 addr} word addresses
//   iDataDataBus          {port2 wdata, port1 wdata}
//   iData1BusEn/2BusEn    per-port request
//   iDataMem1RW/2RW       per-port direction (1 = write)
//   oDataDataBus          {port2 rdata, port1 rdata}, registered
//   oReady                clear sequence finished
//   oCollision            one-cycle pulse on a same-address write/write
//   oCollisionCount       saturating write/write conflict count
//   oAddrErr              sticky out-of-range access flag

// Per-port decode: range check, qualified write, and read mux with write-first
// bypass from the other port.
module embertrail_data_mem_port #(
  parameter int ADDR_W = 8
) (
  input  logic [15:0]       addr,
  input  logic              en,
  input  logic              rw,
  input  logic [15:0]       memWord,
  input  logic              otherWr,
  input  logic [ADDR_W-1:0] otherIdx,
  input  logic [15:0]       otherData,
  output logic              wrValid,
  output logic              rdValid,
  output logic              addrErr,
  output logic [15:0]       rdData
);
  logic inRange;
  assign inRange = (addr[15:ADDR_W] == '0);
  assign wrValid = en & rw & inRange;
  assign rdValid = en & ~rw;
  assign addrErr = en & ~inRange;
  // An out-of-range read loads 0; an in-range read sees the other port's write
  // from the same edge. otherWr is already range-qualified.
  assign rdData  = !inRange ? '0 :
                   (otherWr && otherIdx == addr[ADDR_W-1:0]) ? otherData : memWord;
endmodule

module embertrail_data_mem #(
  parameter int ADDR_W = 8
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [31:0] iDataAddrBus,
  input  logic [31:0] iDataDataBus,
  input  logic        iData1BusEn,
  input  logic        iData2BusEn,
  input  logic        iDataMem1RW,
  input  logic        iDataMem2RW,
  output logic [31:0] oDataDataBus,
  output logic        oReady,
  output logic        oCollision,
  output logic [7:0]  oCollisionCount,
  output logic        oAddrErr
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NP    = 2;

  typedef enum logic {INIT, READY} state_t;
  state_t state, stateNext;

  logic [ADDR_W-1:0] clearPtr;
  logic [15:0]       mem [DEPTH];

  logic [NP-1:0][15:0]       addr, wdata, memWord, rdData, dataOut;
  logic [NP-1:0][ADDR_W-1:0] idx;
  logic [NP-1:0]             en, rw, wrValid, rdValid, addrErr;
  logic                      coll;

  assign addr  = iDataAddrBus;
  assign wdata = iDataDataBus;
  assign en    = {iData2BusEn, iData1BusEn};
  assign rw    = {iDataMem2RW, iDataMem1RW};

  for (genvar p = 0; p < NP; p++) begin : gPort
    assign idx[p]     = addr[p][ADDR_W-1:0];
    assign memWord[p] = mem[idx[p]];
    embertrail_data_mem_port #(.ADDR_W(ADDR_W)) uPort (
      .addr      (addr[p]),
      .en        (en[p]),
      .rw        (rw[p]),
      .memWord   (memWord[p]),
      .otherWr   (wrValid[NP-1-p]),
      .otherIdx  (idx[NP-1-p]),
      .otherData (wdata[NP-1-p]),
      .wrValid   (wrValid[p]),
      .rdValid   (rdValid[p]),
      .addrErr   (addrErr[p]),
      .rdData    (rdData[p])
    );
  end

  // Both writes are range-qualified, so comparing index bits is enough.
  assign coll = wrValid[0] & wrValid[1] & (idx[0] == idx[1]);

  // FSM
  always_ff @(posedge iClock) begin
    if (iReset) state <= INIT;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == INIT && (&clearPtr)) stateNext = READY;
  end

  always_ff @(posedge iClock) begin
    if (iReset)             clearPtr <= '0;
    else if (state == INIT) clearPtr <= clearPtr + 1'b1;
  end

  // Array has no reset of its own; the INIT sweep clears it.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      if (state == INIT) begin
        mem[clearPtr] <= '0;
      end else begin
        // Slot 2 is the later instruction, so it owns a same-address write.
        if (wrValid[0] && !coll) mem[idx[0]] <= wdata[0];
        if (wrValid[1])          mem[idx[1]] <= wdata[1];
      end
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      dataOut         <= '0;
      oCollision      <= 1'b0;
      oCollisionCount <= '0;
      oAddrErr        <= 1'b0;
    end else if (state == READY) begin
      for (int p = 0; p < NP; p++)
        if (rdValid[p]) dataOut[p] <= rdData[p];
      oCollision <= coll;
      if (coll && oCollisionCount != 8'hFF) oCollisionCount <= oCollisionCount + 8'd1;
      if (|addrErr) oAddrErr <= 1'b1;
    end else begin
      oCollision <= 1'b0;
    end
  end

  assign oDataDataBus = dataOut;
  assign oReady       = (state == READY);
endmodule

// File: tb/tb_embertrail_data_mem.sv
module tb_embertrail_data_mem;
  logic        iClock = 1'b0;
  logic        iReset;
  logic [31:0] iDataAddrBus, iDataDataBus;
  logic        iData1BusEn, iData2BusEn, iDataMem1RW, iDataMem2RW;
  logic [31:0] oDataDataBus;
  logic        oReady, oCollision, oAddrErr;
  logic [7:0]  oCollisionCount;

  embertrail_data_mem #(.ADDR_W(8)) dut (
    .iClock(iClock), .iReset(iReset),
    .iDataAddrBus(iDataAddrBus), .iDataDataBus(iDataDataBus),
    .iData1BusEn(iData1BusEn), .iData2BusEn(iData2BusEn),
    .iDataMem1RW(iDataMem1RW), .iDataMem2RW(iDataMem2RW),
    .oDataDataBus(oDataDataBus), .oReady(oReady), .oCollision(oCollision),
    .oCollisionCount(oCollisionCount), .oAddrErr(oAddrErr)
  );

  always #5 iClock = ~iClock;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model: a plain word array, updated by the architectural rules.
  logic [15:0] mdl [256];
  logic [31:0] expOut;
  logic        expColl, expErr;
  int          expCnt;

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mdl[i] = 16'h0;
    expOut = 32'h0; expColl = 1'b0; expErr = 1'b0; expCnt = 0;
  endtask

  // One READY cycle: drive, advance the model, step past the edge.
  task automatic drive(input bit e1, input bit w1, input logic [15:0] a1, input logic [15:0] d1,
                       input bit e2, input bit w2, input logic [15:0] a2, input logic [15:0] d2);
    bit ok1, ok2;
    iData1BusEn = e1; iDataMem1RW = w1; iData2BusEn = e2; iDataMem2RW = w2;
    iDataAddrBus = {a2, a1}; iDataDataBus = {d2, d1};
    ok1 = (a1 < 16'd256); ok2 = (a2 < 16'd256);
    expColl = e1 && w1 && ok1 && e2 && w2 && ok2 && (a1 == a2);
    if (expColl && expCnt < 255) expCnt++;
    if ((e1 && !ok1) || (e2 && !ok2)) expErr = 1'b1;
    // Writes land first (slot order makes slot 2 the survivor), then reads observe them.
    if (e1 && w1 && ok1) mdl[a1[7:0]] = d1;
    if (e2 && w2 && ok2) mdl[a2[7:0]] = d2;
    if (e1 && !w1) expOut[15:0]  = ok1 ? mdl[a1[7:0]] : 16'h0;
    if (e2 && !w2) expOut[31:16] = ok2 ? mdl[a2[7:0]] : 16'h0;
    @(posedge iClock); #1;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  // Hold reset one edge, then run out the clear sweep with junk traffic that must be ignored.
  task automatic reset_and_init(input string tag);
    iReset = 1'b1;
    @(posedge iClock); #1;
    iReset = 1'b0;
    model_clear();
    nChecks++;
    if (oReady !== 1'b0 || oDataDataBus !== 32'h0 || oCollision !== 1'b0 ||
        oCollisionCount !== 8'h0 || oAddrErr !== 1'b0)
      $display("FAIL %s_reset_outputs: got rdy=%b data=%h coll=%b cnt=%0d err=%b want all 0",
               tag, oReady, oDataDataBus, oCollision, oCollisionCount, oAddrErr);
    else nPass++;
    for (int i = 1; i <= 256; i++) begin
      iData1BusEn = 1'b1; iDataMem1RW = 1'b1; iData2BusEn = 1'b1; iDataMem2RW = $urandom_range(0, 1);
      iDataAddrBus = {16'($urandom_range(0, 15)), 16'($urandom_range(0, 15))};
      iDataDataBus = $urandom | 32'h0001_0001;
      @(posedge iClock); #1;
      if (i == 255) begin
        nChecks++;
        if (oReady !== 1'b0) $display("FAIL %s_ready_early: got %b want 0", tag, oReady);
        else nPass++;
      end
    end
    nChecks++;
    if (oReady !== 1'b1) $display("FAIL %s_ready_at_256: got %b want 1", tag, oReady);
    else nPass++;
    nChecks++;
    if (oDataDataBus !== 32'h0) $display("FAIL %s_init_data: got %h want 0", tag, oDataDataBus);
    else nPass++;
    idle();
  endtask

  task automatic test_reset();
    reset_and_init("por");
    drive(1, 0, 16'h00, 16'h0, 1, 0, 16'hFF, 16'h0);
    nChecks++;
    if (oDataDataBus !== 32'h0) $display("FAIL cleared_read: got %h want 0", oDataDataBus);
    else nPass++;
    // Words touched by the ignored INIT traffic must still be zero.
    drive(1, 0, 16'h03, 16'h0, 1, 0, 16'h0C, 16'h0);
    nChecks++;
    if (oDataDataBus !== 32'h0) $display("FAIL init_ignored: got %h want 0", oDataDataBus);
    else nPass++;
  endtask

  task automatic test_write_read();
    drive(1, 0, 16'h07, 16'h0, 0, 0, 16'h0, 16'h0);
    drive(1, 1, 16'h05, 16'h1234, 0, 0, 16'h0, 16'h0);
    drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h05, 16'h0);
    nChecks++;
    if (oDataDataBus !== {16'h1234, expOut[15:0]} || oDataDataBus !== expOut)
      $display("FAIL write_then_read: got %h want %h", oDataDataBus, {16'h1234, expOut[15:0]});
    else nPass++;
    idle();
    nChecks++;
    if (oDataDataBus !== expOut) $display("FAIL read_hold: got %h want %h", oDataDataBus, expOut);
    else nPass++;
  endtask

  task automatic test_collision();
    int bad = 0;
    drive(1, 1, 16'h10, 16'hAAAA, 1, 1, 16'h10, 16'h5555);
    nChecks++;
    if (oCollision !== 1'b1 || oCollisionCount !== 8'd1)
      $display("FAIL ww_collision: got coll=%b cnt=%0d want 1/1", oCollision, oCollisionCount);
    else nPass++;
    drive(1, 0, 16'h10, 16'h0, 1, 0, 16'h10, 16'h0);
    nChecks++;
    if (oCollision !== 1'b0) $display("FAIL coll_pulse_width: got %b want 0", oCollision);
    else nPass++;
    nChecks++;
    if (oDataDataBus !== 32'h5555_5555) $display("FAIL port2_wins: got %h want 55555555", oDataDataBus);
    else nPass++;
    for (int i = 0; i < 300; i++) begin
      drive(1, 1, 16'h10, 16'($urandom), 1, 1, 16'h10, 16'($urandom));
      if (oCollision !== 1'b1 || oCollisionCount !== 8'(expCnt)) bad++;
    end
    nChecks++;
    if (bad != 0) $display("FAIL collision_loop: got %0d bad cycles want 0", bad);
    else nPass++;
    nChecks++;
    if (oCollisionCount !== 8'd255) $display("FAIL coll_saturate: got %0d want 255", oCollisionCount);
    else nPass++;
    idle();
  endtask

  task automatic test_bypass();
    drive(1, 1, 16'h20, 16'hBEEF, 1, 0, 16'h20, 16'h0);
    nChecks++;
    if (oDataDataBus[31:16] !== 16'hBEEF || oCollision !== 1'b0)
      $display("FAIL wr1_rd2_bypass: got %h coll=%b want BEEF coll=0", oDataDataBus[31:16], oCollision);
    else nPass++;
    drive(1, 0, 16'h21, 16'h0, 1, 1, 16'h21, 16'hCAFE);
    nChecks++;
    if (oDataDataBus[15:0] !== 16'hCAFE || oCollision !== 1'b0)
      $display("FAIL wr2_rd1_bypass: got %h coll=%b want CAFE coll=0", oDataDataBus[15:0], oCollision);
    else nPass++;
  endtask

  task automatic test_addr_err();
    drive(1, 1, 16'h00, 16'h4242, 0, 0, 16'h0, 16'h0);
    nChecks++;
    if (oAddrErr !== 1'b0) $display("FAIL err_before: got %b want 0", oAddrErr);
    else nPass++;
    drive(0, 0, 16'h0, 16'h0, 1, 1, 16'h0100, 16'h7777);
    nChecks++;
    if (oAddrErr !== 1'b1) $display("FAIL err_set: got %b want 1", oAddrErr);
    else nPass++;
    idle();
    drive(1, 0, 16'h00, 16'h0, 0, 0, 16'h0, 16'h0);
    nChecks++;
    if (oDataDataBus[15:0] !== 16'h4242 || oAddrErr !== 1'b1)
      $display("FAIL oob_write_dropped: got %h err=%b want 4242 err=1", oDataDataBus[15:0], oAddrErr);
    else nPass++;
    drive(1, 0, 16'h0100, 16'h0, 0, 0, 16'h0, 16'h0);
    nChecks++;
    if (oDataDataBus[15:0] !== 16'h0000) $display("FAIL oob_read_zero: got %h want 0", oDataDataBus[15:0]);
    else nPass++;
  endtask

  task automatic test_random();
    int bad = 0;
    logic [15:0] a1, a2;
    for (int i = 0; i < 400; i++) begin
      a1 = ($urandom_range(0, 15) == 0) ? 16'(16'h0100 | $urandom_range(0, 3)) : 16'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 15) == 0) ? 16'(16'h8000 | $urandom_range(0, 3)) : 16'($urandom_range(0, 7));
      drive($urandom_range(0, 1), $urandom_range(0, 1), a1, 16'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 1), a2, 16'($urandom));
      if (oDataDataBus !== expOut || oCollision !== expColl ||
          oCollisionCount !== 8'(expCnt) || oAddrErr !== expErr) begin
        if (bad < 5)
          $display("FAIL random_cycle_%0d: got data=%h coll=%b cnt=%0d err=%b want %h %b %0d %b",
                   i, oDataDataBus, oCollision, oCollisionCount, oAddrErr, expOut, expColl, expCnt, expErr);
        bad++;
      end
    end
    nChecks++;
    if (bad != 0) $display("FAIL random_total: got %0d bad cycles want 0", bad);
    else nPass++;
  endtask

  task automatic test_reset_mid_init();
    iReset = 1'b1;
    @(posedge iClock); #1;
    iReset = 1'b0;
    repeat (100) begin @(posedge iClock); #1; end
    nChecks++;
    if (oReady !== 1'b0) $display("FAIL mid_init_ready: got %b want 0", oReady);
    else nPass++;
    reset_and_init("mid_init");
  endtask

  task automatic test_reset_ready();
    drive(1, 1, 16'h30, 16'h9999, 1, 1, 16'h30, 16'h1111);
    drive(0, 0, 16'h0, 16'h0, 1, 1, 16'h0200, 16'h1);
    reset_and_init("ready");
    drive(1, 0, 16'h30, 16'h0, 1, 0, 16'h05, 16'h0);
    nChecks++;
    if (oDataDataBus !== 32'h0 || oAddrErr !== 1'b0 || oCollisionCount !== 8'h0)
      $display("FAIL post_reset_state: got data=%h err=%b cnt=%0d want 0/0/0",
               oDataDataBus, oAddrErr, oCollisionCount);
    else nPass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    iReset = 1'b0; iDataAddrBus = '0; iDataDataBus = '0;
    iData1BusEn = 1'b0; iData2BusEn = 1'b0; iDataMem1RW = 1'b0; iDataMem2RW = 1'b0;
    model_clear();
    @(posedge iClock); #1;
    test_reset();
    test_write_read();
    test_collision();
    test_bypass();
    test_addr_err();
    test_random();
    test_reset_mid_init();
    test_reset_ready();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/embertrail_data_mem.md
# embertrail_data_mem

Dual-port data memory responder for the Embertrail core, sitting on the far side of the control unit's data-memory interface. It accepts two independent word accesses per cycle, one per instruction slot, on the packed 32-bit address/data buses. It returns read data with a one-cycle registered latency and resolves same-address conflicts deterministically. After reset it runs a clear sequence before accepting traffic, and it flags out-of-range accesses and write collisions for debug.

## Interface
- ADDR_W, 8, word-address width; depth = 2^ADDR_W 16-bit words
- iClock  in  1  clock, all state updates on rising edge
- iReset  in  1  synchronous, active-high reset
- iDataAddrBus  in  32  [15:0] port-1 word address, [31:16] port-2 word address
- iDataDataBus  in  32  [15:0] port-1 write data, [31:16] port-2 write data
- iData1BusEn  in  1  port-1 access request
- iData2BusEn  in  1  port-2 access request
- iDataMem1RW  in  1  port-1 direction: 1 = write, 0 = read
- iDataMem2RW  in  1  port-2 direction: 1 = write, 0 = read
- oDataDataBus  out  32  [15:0] port-1 read data, [31:16] port-2 read data, registered
- oReady  out  1  high once the clear sequence is complete
- oCollision  out  1  one-cycle pulse on a same-address write/write conflict
- oCollisionCount  out  8  saturating count of write/write conflicts
- oAddrErr  out  1  sticky out-of-range access flag

## Operation
- Reset values: oDataDataBus = 0, oReady = 0, oCollision = 0, oCollisionCount = 0, oAddrErr = 0. The clear pointer is 0 and the state is INIT.
- **INIT state:**
  - Each cycle writes 0 to mem[clearPtr] and increments clearPtr.
  - When clearPtr = 2^ADDR_W-1 has been written, the block goes to READY.
  - All bus requests are ignored in this state, and oDataDataBus holds 0.
- **READY state:** each port is evaluated independently at each rising edge.
  - En=1, RW=1: mem[addr] <= write data.
  - En=1, RW=0: the port's read-data half <= mem[addr].
  - En=0: the port's read-data half holds its last value.
- **Address range:**
  - Only addr[ADDR_W-1:0] indexes the array.
  - If any bit addr[15:ADDR_W] is set on an enabled port, the access is suppressed: a write is dropped, and a read loads 0.
  - oAddrErr sets and stays set until iReset.
- **Write/write, same address:** port 2 wins, because slot 2 is the later instruction. Port-1 data is discarded. oCollision pulses, and oCollisionCount increments and saturates at 255.
- **Write/read, same address (either orientation):** write-first. The reading port returns the data written in that same cycle. This is not a collision.
- **Read/read, same address:** both halves return the same stored word. This is not a collision.
- A suppressed (out-of-range) access never participates in collision or bypass logic.
- Reset asserted mid-INIT or mid-traffic:
  - The FSM returns to INIT with clearPtr = 0.
  - All outputs return to their reset values.
  - The clear sequence restarts from word 0.

## Timing
- INIT lasts exactly 2^ADDR_W cycles after the cycle in which iReset is deasserted. For ADDR_W=8, oReady rises at the 256th rising edge after reset release.
- Read latency is 1 cycle. The request is sampled at edge N and the data is valid on oDataDataBus after edge N, remaining stable until the next read on that port. The control unit samples at its write-back stage, at least one edge later.
- Write commit: a write sampled at edge N is visible to a read sampled at edge N via bypass, and to any read at edge N+1 onward.
- oCollision is registered. It is high for the single cycle following the conflicting edge.
- oAddrErr is registered. It rises the cycle after the first offending access.
- There is no back-pressure. Every request in READY completes in one cycle, and there is no stall output.

## Test plan
- Reset, then hold both enables at 0. Required: oReady low for 256 cycles, then high. A subsequent read of addresses 0x00 and 0xFF returns 0x0000 on both halves.
- Port-1 write 0x1234 to address 0x05, then next cycle port-2 read of 0x05. Required: oDataDataBus[31:16] = 0x1234 one cycle later, and [15:0] unchanged.
- Both ports write address 0x10 in the same cycle (port 1 = 0xAAAA, port 2 = 0x5555), then read it back. Required: 0x5555, a one-cycle oCollision pulse, and oCollisionCount = 1. Repeat 300 times. Required: count saturates at 255.
- Port-1 write 0xBEEF to 0x20 while port 2 reads 0x20 in the same cycle. Required: port-2 read data = 0xBEEF next cycle, and oCollision stays low.
- Port-2 write 0x7777 to address 0x0100 (out of range for ADDR_W=8). Required: oAddrErr high next cycle and stays high. A read of 0x00 returns its prior value, not 0x7777. A port-1 read of 0x0100 returns 0.
- Assert iReset for one cycle at INIT cycle 100, and separately after writing data in READY. Required: oReady drops, then returns 256 cycles after release. Previously written data reads 0, and oAddrErr and oCollisionCount read 0.
